player_shot_reporter: RTL and testbench

- Owns the player's single shot and acts as the initiator side of the enemy-kill interface.
- Spawns a bullet on fire and moves it up once per frame.
- Detects overlap between the bullet and the enemy layer's pixel_valid during the LCD scan, then presents the hit coordinate on killed_enemy_x/killed_enemy_y with valid_enemy_collision.
- Holds that request until the enemy block acknowledges with a non-zero plus_score.
- Also renders the bullet for the LCD mixer.

---
 rtl/player_shot_reporter.sv | 182 ++++++++++++++++++
 tb/tb_player_shot_reporter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_shot_reporter.sv
// Player shot owner and kill-request initiator: spawns, moves and renders the bullet,
// latches the first enemy overlap per frame and holds it until the enemy block scores it.
// Optional ack timeout in REPORT: define SHOT_ACK_TIMEOUT_EN.
module player_shot_reporter #(
    parameter int          PLAYER_Y        = 440,
    parameter int          GUN_OFFSET      = 21,
    parameter int          BULLET_W        = 4,
    parameter int          BULLET_H        = 12,
    parameter int          BULLET_SPEED    = 8,
    parameter int          Y_MIN           = 0,
    parameter int          COOLDOWN_FRAMES = 4,
    parameter logic [23:0] BULLET_COLOR    = 24'hFFFFFF
`ifdef SHOT_ACK_TIMEOUT_EN
    ,
    parameter int          ACK_TIMEOUT     = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lcd_xpos,
    input  logic [11:0] lcd_ypos,
    input  logic        enable,
    input  logic        freeze,
    input  logic        fire,
    input  logic [11:0] player_x,
    input  logic        enemy_pixel_valid,
    input  logic [1:0]  plus_score,
    output logic [11:0] killed_enemy_x,
    output logic [11:0] killed_enemy_y,
    output logic        valid_enemy_collision,
    output logic [23:0] bullet_pixel,
    output logic        bullet_pixel_valid,
    output logic        shot_active
);

    typedef enum logic [1:0] {IDLE, FLYING, REPORT, COOLDOWN} state_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } coord_t;

    localparam int CD_W    = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES);
    localparam int CD_LAST = (COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1;

    localparam logic [11:0] SPAWN_Y  = 12'(PLAYER_Y - BULLET_H);
    localparam logic [11:0] LOST_Y   = 12'(Y_MIN + BULLET_SPEED);
    localparam logic [11:0] GUN_X    = 12'(GUN_OFFSET);
    localparam logic [11:0] STEP_Y   = 12'(BULLET_SPEED);
    localparam logic [12:0] W13      = 13'(BULLET_W);
    localparam logic [12:0] H13      = 13'(BULLET_H);
    localparam logic [CD_W-1:0] CD_END = CD_W'(CD_LAST);

    state_t          state, state_nx;
    coord_t          bullet, bullet_nx;
    coord_t          killed, killed_nx;
    logic            hit, hit_nx;
    logic [CD_W-1:0] cd_cnt, cd_cnt_nx;
    logic            valid_nx;

    logic frame_rate;
    logic in_x, in_y, in_bullet;

`ifdef SHOT_ACK_TIMEOUT_EN
    localparam logic [10:0] ACK_END = 11'(ACK_TIMEOUT - 1);
    logic [10:0] ack_cnt, ack_cnt_nx;
`endif

    assign frame_rate = (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0);

    // Right/bottom edges are formed in 13 bits so a bullet near 4095 cannot wrap.
    assign in_x = (lcd_xpos >= bullet.x) && ({1'b0, lcd_xpos} < ({1'b0, bullet.x} + W13));
    assign in_y = (lcd_ypos >= bullet.y) && ({1'b0, lcd_ypos} < ({1'b0, bullet.y} + H13));
    assign in_bullet = in_x && in_y;

    always_comb begin
        state_nx  = state;
        bullet_nx = bullet;
        killed_nx = killed;
        hit_nx    = hit;
        cd_cnt_nx = cd_cnt;
`ifdef SHOT_ACK_TIMEOUT_EN
        ack_cnt_nx = ack_cnt;
`endif
        if (freeze) begin
            state_nx = state;
        end else if (!enable) begin
            state_nx = IDLE;
            hit_nx   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        bullet_nx.x = player_x + GUN_X;
                        bullet_nx.y = SPAWN_Y;
                        state_nx    = FLYING;
                    end
                end
                FLYING: begin
                    if (!frame_rate) begin
                        // Only the first qualifying pixel of the frame is kept.
                        if (in_bullet && enemy_pixel_valid && !hit) begin
                            hit_nx      = 1'b1;
                            killed_nx.x = lcd_xpos;
                            killed_nx.y = lcd_ypos;
                        end
                    end else if (hit) begin
                        hit_nx   = 1'b0;
                        state_nx = REPORT;
`ifdef SHOT_ACK_TIMEOUT_EN
                        ack_cnt_nx = '0;
`endif
                    end else if (bullet.y < LOST_Y) begin
                        cd_cnt_nx = '0;
                        state_nx  = COOLDOWN;
                    end else begin
                        bullet_nx.y = bullet.y - STEP_Y;
                    end
                end
                REPORT: begin
                    if (plus_score != 2'b00) begin
                        cd_cnt_nx = '0;
                        state_nx  = COOLDOWN;
                    end
`ifdef SHOT_ACK_TIMEOUT_EN
                    else if (ack_cnt == ACK_END) begin
                        cd_cnt_nx = '0;
                        state_nx  = COOLDOWN;
                    end else begin
                        ack_cnt_nx = ack_cnt + 11'd1;
                    end
`endif
                end
                COOLDOWN: begin
                    if (frame_rate) begin
                        if (cd_cnt >= CD_END) begin
                            cd_cnt_nx = '0;
                            state_nx  = IDLE;
                        end else begin
                            cd_cnt_nx = cd_cnt + 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        // Registered request: high exactly while the FSM sits in REPORT.
        valid_nx = (state_nx == REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            bullet                <= '0;
            killed                <= '0;
            hit                   <= 1'b0;
            cd_cnt                <= '0;
            valid_enemy_collision <= 1'b0;
        end else begin
            state                 <= state_nx;
            bullet                <= bullet_nx;
            killed                <= killed_nx;
            hit                   <= hit_nx;
            cd_cnt                <= cd_cnt_nx;
            valid_enemy_collision <= valid_nx;
        end
    end

`ifdef SHOT_ACK_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ack_cnt <= '0;
        else     ack_cnt <= ack_cnt_nx;
    end
`endif

    assign killed_enemy_x     = killed.x;
    assign killed_enemy_y     = killed.y;
    assign bullet_pixel_valid = (state == FLYING) && in_bullet;
    assign bullet_pixel       = bullet_pixel_valid ? BULLET_COLOR : 24'h000000;
    assign shot_active        = (state != IDLE);

endmodule

// File: tb/tb_player_shot_reporter.sv
// Directed plus randomized bench for player_shot_reporter against a cycle reference model.
module tb_player_shot_reporter;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] lcd_xpos, lcd_ypos;
    logic        enable, freeze, fire;
    logic [11:0] player_x;
    logic        enemy_pixel_valid;
    logic [1:0]  plus_score;
    logic [11:0] killed_enemy_x, killed_enemy_y;
    logic        valid_enemy_collision;
    logic [23:0] bullet_pixel;
    logic        bullet_pixel_valid;
    logic        shot_active;

    player_shot_reporter dut (
        .clk(clk), .rst(rst), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
        .enable(enable), .freeze(freeze), .fire(fire), .player_x(player_x),
        .enemy_pixel_valid(enemy_pixel_valid), .plus_score(plus_score),
        .killed_enemy_x(killed_enemy_x), .killed_enemy_y(killed_enemy_y),
        .valid_enemy_collision(valid_enemy_collision), .bullet_pixel(bullet_pixel),
        .bullet_pixel_valid(bullet_pixel_valid), .shot_active(shot_active)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_FLY = 1, M_REP = 2, M_CD = 3;

    int m_st, m_bx, m_by, m_kx, m_ky, m_cd;
    bit m_hit;
    int checks = 0, errors = 0;
    bit last_pv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_bullet(input int x, input int y);
        return x >= m_bx && x < m_bx + 4 && y >= m_by && y < m_by + 12;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_bx = 0; m_by = 0; m_kx = 0; m_ky = 0; m_cd = 0; m_hit = 0;
    endtask

    // Game rules applied once per clock from the inputs presented in that cycle.
    task automatic model_step(input int x, input int y);
        bit fr;
        fr = (x == 0) && (y == 0);
        if (freeze) return;
        if (!enable) begin m_st = M_IDLE; m_hit = 0; return; end
        case (m_st)
            M_IDLE: if (fire) begin m_bx = (int'(player_x) + 21) % 4096; m_by = 428; m_st = M_FLY; end
            M_FLY: begin
                if (!fr) begin
                    if (!m_hit && enemy_pixel_valid && in_bullet(x, y)) begin
                        m_hit = 1; m_kx = x; m_ky = y;
                    end
                end else if (m_hit) begin
                    m_st = M_REP; m_hit = 0;
                end else if (m_by < 8) begin
                    m_st = M_CD; m_cd = 0;
                end else begin
                    m_by = m_by - 8;
                end
            end
            M_REP: if (plus_score != 2'b00) begin m_st = M_CD; m_cd = 0; end
            M_CD: if (fr) begin m_cd++; if (m_cd >= 4) m_st = M_IDLE; end
            default: m_st = M_IDLE;
        endcase
    endtask

    // One clock: drive at posedge+1, check rendering before the edge, registers after it.
    task automatic cyc(input int x, input int y, input bit f = 0, input bit e = 0,
                       input logic [1:0] ps = 2'b00);
        bit exp_pv;
        lcd_xpos = 12'(x); lcd_ypos = 12'(y);
        fire = f; enemy_pixel_valid = e; plus_score = ps;
        #1;
        exp_pv  = (m_st == M_FLY) && in_bullet(x, y);
        last_pv = bullet_pixel_valid;
        chk("pix_valid", {31'b0, bullet_pixel_valid}, {31'b0, exp_pv});
        chk("pix_rgb", {8'b0, bullet_pixel}, exp_pv ? 32'h00FFFFFF : 32'h0);
        @(posedge clk);
        model_step(x, y);
        #1;
        chk("shot_active", {31'b0, shot_active}, {31'b0, m_st != M_IDLE});
        chk("valid", {31'b0, valid_enemy_collision}, {31'b0, m_st == M_REP});
        chk("killed_x", {20'b0, killed_enemy_x}, 32'(m_kx));
        chk("killed_y", {20'b0, killed_enemy_y}, 32'(m_ky));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_active"}, {31'b0, shot_active}, 32'h0);
        chk({tag, "_valid"}, {31'b0, valid_enemy_collision}, 32'h0);
        chk({tag, "_kx"}, {20'b0, killed_enemy_x}, 32'h0);
        chk({tag, "_ky"}, {20'b0, killed_enemy_y}, 32'h0);
        chk({tag, "_pix"}, {7'b0, bullet_pixel_valid, bullet_pixel}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; freeze = 1'b0; fire = 1'b0; player_x = 12'd100;
        lcd_xpos = 12'd121; lcd_ypos = 12'd428; enemy_pixel_valid = 1'b0; plus_score = 2'b00;
        model_reset();
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Spawn and rendering footprint
        cyc(5, 5, 1);
        chk("spawn_active", {31'b0, shot_active}, 32'h1);
        cyc(121, 428); chk("spawn_px_tl", {31'b0, last_pv}, 32'h1);
        cyc(124, 439); chk("spawn_px_br", {31'b0, last_pv}, 32'h1);
        cyc(125, 428); chk("spawn_px_right", {31'b0, last_pv}, 32'h0);
        cyc(120, 428); chk("spawn_px_left", {31'b0, last_pv}, 32'h0);

        // Movement, miss at the top, cooldown length, fire ignored in cooldown
        frames(3);
        cyc(121, 404); chk("move_px_404", {31'b0, last_pv}, 32'h1);
        cyc(121, 403); chk("move_px_403", {31'b0, last_pv}, 32'h0);
        frames(50);
        cyc(121, 4); chk("top_px_4", {31'b0, last_pv}, 32'h1);
        frame_and_miss: begin
            frames(1);
            chk("miss_cooldown", {31'b0, shot_active}, 32'h1);
        end
        cyc(5, 5, 1);
        frames(3);
        cyc(121, 428); chk("cd_fire_ignored", {31'b0, last_pv}, 32'h0);
        chk("cd_still_active", {31'b0, shot_active}, 32'h1);
        frames(1);
        chk("cd_done_idle", {31'b0, shot_active}, 32'h0);

        // Hit, report, held request, ack
        cyc(5, 5, 1);
        frames(16);
        cyc(122, 300, 0, 1);
        cyc(123, 301, 0, 1);
        frames(1);
        chk("hit_valid", {31'b0, valid_enemy_collision}, 32'h1);
        chk("hit_kx", {20'b0, killed_enemy_x}, 32'd122);
        chk("hit_ky", {20'b0, killed_enemy_y}, 32'd300);
        for (int i = 0; i < 50; i++) cyc(7, 7);
        chk("hold_valid", {31'b0, valid_enemy_collision}, 32'h1);
        chk("hold_kx", {20'b0, killed_enemy_x}, 32'd122);
        cyc(7, 7, 0, 0, 2'b01);
        chk("ack_drop", {31'b0, valid_enemy_collision}, 32'h0);
        chk("ack_cooldown", {31'b0, shot_active}, 32'h1);
        frames(4);
        chk("ack_idle", {31'b0, shot_active}, 32'h0);

        // First qualifying pixel of the frame wins
        cyc(5, 5, 1);
        frames(16);
        cyc(121, 300, 0, 1);
        cyc(123, 301, 0, 1);
        frames(1);
        chk("first_kx", {20'b0, killed_enemy_x}, 32'd121);
        chk("first_ky", {20'b0, killed_enemy_y}, 32'd300);
        cyc(7, 7, 0, 0, 2'b10);
        frames(4);

        // Freeze holds position; rendering continues
        cyc(5, 5, 1);
        frames(2);
        freeze = 1'b1;
        frames(5);
        cyc(121, 412); chk("frz_render", {31'b0, last_pv}, 32'h1);
        freeze = 1'b0;
        cyc(121, 412); chk("frz_px_412", {31'b0, last_pv}, 32'h1);
        cyc(121, 411); chk("frz_px_411", {31'b0, last_pv}, 32'h0);

        // Enable low forces IDLE
        enable = 1'b0;
        cyc(7, 7);
        chk("disable_idle", {31'b0, shot_active}, 32'h0);
        enable = 1'b1;

        // No ack timeout in the default build; then async reset mid-REPORT
        cyc(5, 5, 1);
        frames(16);
        cyc(122, 300, 0, 1);
        frames(1);
        for (int i = 0; i < 5000; i++) cyc(7, 7);
        chk("no_timeout_valid", {31'b0, valid_enemy_collision}, 32'h1);
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            int x, y;
            logic [1:0] ps;
            bit f, e;
            if ($urandom_range(0, 15) == 0) begin
                x = 0; y = 0;
            end else begin
                x = m_bx - 2 + int'($urandom_range(0, 7));
                y = m_by - 2 + int'($urandom_range(0, 15));
                if (x < 0) x = 0;
                if (y < 1) y = 1;
                if (x > 4095) x = 4095;
                if (y > 4095) y = 4095;
            end
            f  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 2) == 0);
            ps = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            freeze   = ($urandom_range(0, 24) == 0);
            enable   = ($urandom_range(0, 59) != 0);
            player_x = 12'($urandom_range(0, 600));
            cyc(x, y, f, e, ps);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
